writeback_stage: RTL and testbench

- Final pipeline stage; drives the integer register file write port (rf_wr_en/rf_wr_addr/rf_wr_data).
- Accepts retiring instructions from MEM over a valid/ready handshake.
- Selects the result: ALU, PC+4, or load data. Load data arrives from data memory with variable latency and is byte/half/word extracted and sign/zero extended.
- Write port is registered: one write per retired instruction, x0 writes suppressed.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/writeback_stage_load_extend.sv | 36 +++
 rtl/writeback_stage.sv | 193 +++++++++++++++++++
 tb/tb_writeback_stage.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result-source select,
// load funct3 codes and the writeback FSM state type.
package wb_pkg;

  localparam logic [1:0] RES_ALU  = 2'd0;
  localparam logic [1:0] RES_LOAD = 2'd1;
  localparam logic [1:0] RES_PC4  = 2'd2;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// load_extend: purely combinational byte/half/word extraction from an
// aligned memory word, with sign or zero extension selected by funct3.
// Unknown funct3 codes pass the full word through.
module load_extend
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword; halfword ignores offset bit 0
  always_comb begin
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = word[{offset[1], 4'b0000} +: 16];
  end

  // Extend the selected lane according to the load type
  always_comb begin
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LW:   data = word;
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage driving the register file write
// port. Non-load results (and loads whose data arrives with the accept)
// write one cycle later; other loads park in WAIT_LOAD until data arrives
// or the timeout aborts them with a one-cycle load_err pulse.
// Optional feature: define WB_INSTRET_EN to add a 64-bit retired
// instruction counter output (instret).
module writeback_stage
  import wb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  output logic            wb_ready,
  input  logic            wb_reg_write,
  input  logic [4:0]      wb_rd,
  input  logic [1:0]      wb_result_src,
  input  logic [XLEN-1:0] wb_alu_result,
  input  logic [XLEN-1:0] wb_pc_plus4,
  input  logic [2:0]      wb_funct3,
  input  logic            mem_rdata_valid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_wr_en,
  output logic [4:0]      rf_wr_addr,
  output logic [XLEN-1:0] rf_wr_data,
  output logic            wb_busy,
  output logic            load_err
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]     instret
`endif
);

  localparam int               CNT_W    = $clog2(LOAD_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOAD_TIMEOUT - 1);

  wb_state_e        state;
  wb_state_e        state_next;
  logic [CNT_W-1:0] wait_cnt;

  // Load parked while waiting for memory data
  logic             pend_reg_write;
  logic [4:0]       pend_rd;
  logic [2:0]       pend_funct3;
  logic [1:0]       pend_offset;

  logic             accept;
  logic             start_wait;
  logic             complete;
  logic             timeout;
  logic             cmp_reg_write;
  logic [4:0]       cmp_rd;
  logic [XLEN-1:0]  cmp_data;
  logic [2:0]       ext_funct3;
  logic [1:0]       ext_offset;
  logic [XLEN-1:0]  ext_data;

  assign wb_ready = (state == WB_IDLE);
  assign wb_busy  = (state == WB_WAIT_LOAD);
  assign accept   = wb_ready && wb_valid;

  // The extractor sees the live instruction in IDLE and the parked load otherwise
  assign ext_funct3 = wb_busy ? pend_funct3 : wb_funct3;
  assign ext_offset = wb_busy ? pend_offset : wb_alu_result[1:0];

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3 (ext_funct3),
    .offset (ext_offset),
    .word   (mem_rdata),
    .data   (ext_data)
  );

  // Next-state, completion and result selection
  always_comb begin
    state_next    = state;
    start_wait    = 1'b0;
    complete      = 1'b0;
    timeout       = 1'b0;
    cmp_reg_write = 1'b0;
    cmp_rd        = 5'd0;
    cmp_data      = {XLEN{1'b0}};
    case (state)
      WB_IDLE: begin
        if (accept) begin
          if ((wb_result_src != RES_LOAD) || mem_rdata_valid) begin
            complete      = 1'b1;
            cmp_reg_write = wb_reg_write;
            cmp_rd        = wb_rd;
            case (wb_result_src)
              RES_ALU:  cmp_data = wb_alu_result;
              RES_LOAD: cmp_data = ext_data;
              RES_PC4:  cmp_data = wb_pc_plus4;
              default:  cmp_data = {XLEN{1'b0}};
            endcase
          end else begin
            start_wait = 1'b1;
            state_next = WB_WAIT_LOAD;
          end
        end else begin
          state_next = WB_IDLE;
        end
      end
      WB_WAIT_LOAD: begin
        if (mem_rdata_valid) begin
          complete      = 1'b1;
          cmp_reg_write = pend_reg_write;
          cmp_rd        = pend_rd;
          cmp_data      = ext_data;
          state_next    = WB_IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          timeout    = 1'b1;
          state_next = WB_IDLE;
        end else begin
          state_next = WB_WAIT_LOAD;
        end
      end
      default: state_next = WB_IDLE;
    endcase
  end

  // State register and load wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= WB_IDLE;
      wait_cnt <= {CNT_W{1'b0}};
    end else begin
      state <= state_next;
      if (start_wait) begin
        wait_cnt <= {CNT_W{1'b0}};
      end else if (wb_busy && !mem_rdata_valid) begin
        wait_cnt <= wait_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        wait_cnt <= wait_cnt;
      end
    end
  end

  // Capture the destination and extraction controls of a stalled load
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg_write <= 1'b0;
      pend_rd        <= 5'd0;
      pend_funct3    <= 3'd0;
      pend_offset    <= 2'd0;
    end else if (start_wait) begin
      pend_reg_write <= wb_reg_write;
      pend_rd        <= wb_rd;
      pend_funct3    <= wb_funct3;
      pend_offset    <= wb_alu_result[1:0];
    end else begin
      pend_reg_write <= pend_reg_write;
      pend_rd        <= pend_rd;
      pend_funct3    <= pend_funct3;
      pend_offset    <= pend_offset;
    end
  end

  // Registered write port; x0 writes are suppressed and addr/data hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr_en   <= 1'b0;
      rf_wr_addr <= 5'd0;
      rf_wr_data <= {XLEN{1'b0}};
      load_err   <= 1'b0;
    end else begin
      rf_wr_en <= complete && cmp_reg_write && (cmp_rd != 5'd0);
      load_err <= timeout;
      if (complete && cmp_reg_write && (cmp_rd != 5'd0)) begin
        rf_wr_addr <= cmp_rd;
        rf_wr_data <= cmp_data;
      end else begin
        rf_wr_addr <= rf_wr_addr;
        rf_wr_data <= rf_wr_data;
      end
    end
  end

`ifdef WB_INSTRET_EN
  // Count every completed instruction, including ones that do not write
  always_ff @(posedge clk) begin
    if (rst) begin
      instret <= 64'd0;
    end else if (complete) begin
      instret <= instret + 64'd1;
    end else begin
      instret <= instret;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios followed by a
// randomized run checked against a transaction-level reference model.
module tb_writeback_stage;

  localparam int XLEN         = 32;
  localparam int LOAD_TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_result_src;
  logic [31:0] wb_alu_result;
  logic [31:0] wb_pc_plus4;
  logic [2:0]  wb_funct3;
  logic        mem_rdata_valid;
  logic [31:0] mem_rdata;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        wb_busy;
  logic        load_err;
`ifdef WB_INSTRET_EN
  logic [63:0] instret;
`endif

  int vec;
  int miscomp;

  writeback_stage #(.XLEN(XLEN), .LOAD_TIMEOUT(LOAD_TIMEOUT)) dut (
    .clk             (clk),
    .rst             (rst),
    .wb_valid        (wb_valid),
    .wb_ready        (wb_ready),
    .wb_reg_write    (wb_reg_write),
    .wb_rd           (wb_rd),
    .wb_result_src   (wb_result_src),
    .wb_alu_result   (wb_alu_result),
    .wb_pc_plus4     (wb_pc_plus4),
    .wb_funct3       (wb_funct3),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata       (mem_rdata),
    .rf_wr_en        (rf_wr_en),
    .rf_wr_addr      (rf_wr_addr),
    .rf_wr_data      (rf_wr_data),
    .wb_busy         (wb_busy),
    .load_err        (load_err)
`ifdef WB_INSTRET_EN
    ,
    .instret         (instret)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] src, input logic [31:0] alu,
                       input logic [2:0] f3, input logic mv, input logic [31:0] md);
    wb_valid        = v;
    wb_reg_write    = rw;
    wb_rd           = rd;
    wb_result_src   = src;
    wb_alu_result   = alu;
    wb_pc_plus4     = 32'h0000_0104;
    wb_funct3       = f3;
    mem_rdata_valid = mv;
    mem_rdata       = md;
  endtask

  // Reference load extraction using shifts/masks and two's-complement wrap
  function automatic logic [31:0] ext_ref(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * off)) & 32'h0000_00FF;
    h = (w >> (16 * off[1])) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)    ? b - 32'd256     : b;
      3'b001:  return (h >= 32'h8000)   ? h - 32'h1_0000  : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  task automatic test_reset();
    drive(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 3'd0, 1'b0, 32'd0);
    rst = 1'b1;
    tick();
    tick();
    vec++; if (rf_wr_en !== 1'b0)       begin miscomp++; $display("FAIL rst_en: got %b want 0", rf_wr_en); end
    vec++; if (rf_wr_addr !== 5'd0)     begin miscomp++; $display("FAIL rst_addr: got %0d want 0", rf_wr_addr); end
    vec++; if (rf_wr_data !== 32'd0)    begin miscomp++; $display("FAIL rst_data: got %h want 0", rf_wr_data); end
    vec++; if (load_err !== 1'b0)       begin miscomp++; $display("FAIL rst_err: got %b want 0", load_err); end
    rst = 1'b0;
    tick();
    vec++; if (wb_ready !== 1'b1)       begin miscomp++; $display("FAIL rst_ready: got %b want 1", wb_ready); end
    vec++; if (wb_busy !== 1'b0)        begin miscomp++; $display("FAIL rst_busy: got %b want 0", wb_busy); end
`ifdef WB_INSTRET_EN
    vec++; if (instret !== 64'd0)       begin miscomp++; $display("FAIL rst_instret: got %0d want 0", instret); end
`endif
  endtask

  task automatic test_alu();
    drive(1'b1, 1'b1, 5'd5, 2'd0, 32'h1234_5678, 3'd0, 1'b0, 32'd0);
    vec++; if (wb_ready !== 1'b1)          begin miscomp++; $display("FAIL alu_ready: got %b want 1", wb_ready); end
    tick();
    wb_valid = 1'b0;
    vec++; if (rf_wr_en !== 1'b1)          begin miscomp++; $display("FAIL alu_en: got %b want 1", rf_wr_en); end
    vec++; if (rf_wr_addr !== 5'd5)        begin miscomp++; $display("FAIL alu_addr: got %0d want 5", rf_wr_addr); end
    vec++; if (rf_wr_data !== 32'h1234_5678) begin miscomp++; $display("FAIL alu_data: got %h want 12345678", rf_wr_data); end
    tick();
    vec++; if (rf_wr_en !== 1'b0)          begin miscomp++; $display("FAIL alu_en_drop: got %b want 0", rf_wr_en); end
    vec++; if (rf_wr_data !== 32'h1234_5678) begin miscomp++; $display("FAIL alu_hold: got %h want 12345678", rf_wr_data); end
  endtask

  task automatic test_rd0();
`ifdef WB_INSTRET_EN
    logic [63:0] before;
    before = 64'd1;
`endif
    drive(1'b1, 1'b1, 5'd0, 2'd0, 32'hDEAD_BEEF, 3'd0, 1'b0, 32'd0);
    tick();
    wb_valid = 1'b0;
    vec++; if (rf_wr_en !== 1'b0)            begin miscomp++; $display("FAIL rd0_en: got %b want 0", rf_wr_en); end
    vec++; if (rf_wr_addr !== 5'd5)          begin miscomp++; $display("FAIL rd0_addr_hold: got %0d want 5", rf_wr_addr); end
    vec++; if (rf_wr_data !== 32'h1234_5678) begin miscomp++; $display("FAIL rd0_data_hold: got %h want 12345678", rf_wr_data); end
`ifdef WB_INSTRET_EN
    vec++; if (instret !== before + 64'd1)   begin miscomp++; $display("FAIL rd0_instret: got %0d want %0d", instret, before + 64'd1); end
`endif
    tick();
  endtask

  task automatic test_load_same_cycle();
    logic [2:0]  f3s  [3];
    logic [31:0] alus [3];
    logic [31:0] exps [3];
    f3s[0] = 3'b000; alus[0] = 32'h0000_1003; exps[0] = 32'hFFFF_FF80;
    f3s[1] = 3'b100; alus[1] = 32'h0000_1003; exps[1] = 32'h0000_0080;
    f3s[2] = 3'b101; alus[2] = 32'h0000_1002; exps[2] = 32'h0000_80FF;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'd7, 2'd1, alus[i], f3s[i], 1'b1, 32'h80FF_0000);
      tick();
      drive(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 3'd0, 1'b0, 32'd0);
      vec++; if (rf_wr_en !== 1'b1)   begin miscomp++; $display("FAIL ld_same_en[%0d]: got %b want 1", i, rf_wr_en); end
      vec++; if (rf_wr_addr !== 5'd7) begin miscomp++; $display("FAIL ld_same_addr[%0d]: got %0d want 7", i, rf_wr_addr); end
      vec++; if (rf_wr_data !== exps[i]) begin miscomp++; $display("FAIL ld_same_data[%0d]: got %h want %h", i, rf_wr_data, exps[i]); end
    end
    tick();
  endtask

  task automatic test_load_wait();
    drive(1'b1, 1'b1, 5'd9, 2'd1, 32'h0000_2000, 3'b010, 1'b0, 32'd0);
    tick();
    // A younger ALU op is held valid for the whole wait
    drive(1'b1, 1'b1, 5'd3, 2'd0, 32'h55AA_55AA, 3'd0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mem_rdata_valid = 1'b1;
        mem_rdata       = 32'hCAFE_F00D;
      end
      vec++; if (wb_ready !== 1'b0) begin miscomp++; $display("FAIL ldw_ready[%0d]: got %b want 0", i, wb_ready); end
      vec++; if (wb_busy !== 1'b1)  begin miscomp++; $display("FAIL ldw_busy[%0d]: got %b want 1", i, wb_busy); end
      vec++; if (rf_wr_en !== 1'b0) begin miscomp++; $display("FAIL ldw_en[%0d]: got %b want 0", i, rf_wr_en); end
      tick();
    end
    mem_rdata_valid = 1'b0;
    vec++; if (rf_wr_en !== 1'b1)            begin miscomp++; $display("FAIL ldw_wr_en: got %b want 1", rf_wr_en); end
    vec++; if (rf_wr_addr !== 5'd9)          begin miscomp++; $display("FAIL ldw_wr_addr: got %0d want 9", rf_wr_addr); end
    vec++; if (rf_wr_data !== 32'hCAFE_F00D) begin miscomp++; $display("FAIL ldw_wr_data: got %h want cafef00d", rf_wr_data); end
    vec++; if (wb_ready !== 1'b1)            begin miscomp++; $display("FAIL ldw_ready_back: got %b want 1", wb_ready); end
    tick();
    wb_valid = 1'b0;
    vec++; if (rf_wr_en !== 1'b1)            begin miscomp++; $display("FAIL ldw_held_en: got %b want 1", rf_wr_en); end
    vec++; if (rf_wr_addr !== 5'd3)          begin miscomp++; $display("FAIL ldw_held_addr: got %0d want 3", rf_wr_addr); end
    vec++; if (rf_wr_data !== 32'h55AA_55AA) begin miscomp++; $display("FAIL ldw_held_data: got %h want 55aa55aa", rf_wr_data); end
    tick();
    vec++; if (rf_wr_en !== 1'b0)            begin miscomp++; $display("FAIL ldw_held_once: got %b want 0", rf_wr_en); end
  endtask

  task automatic test_timeout();
    drive(1'b1, 1'b1, 5'd10, 2'd1, 32'h0000_3000, 3'b010, 1'b0, 32'd0);
    tick();
    wb_valid = 1'b0;
    for (int i = 0; i < LOAD_TIMEOUT; i++) begin
      vec++; if (wb_busy !== 1'b1 || load_err !== 1'b0 || rf_wr_en !== 1'b0) begin
        miscomp++; $display("FAIL to_wait[%0d]: got busy=%b err=%b en=%b want 1 0 0", i, wb_busy, load_err, rf_wr_en);
      end
      tick();
    end
    vec++; if (load_err !== 1'b1) begin miscomp++; $display("FAIL to_err: got %b want 1", load_err); end
    vec++; if (rf_wr_en !== 1'b0) begin miscomp++; $display("FAIL to_en: got %b want 0", rf_wr_en); end
    vec++; if (wb_ready !== 1'b1) begin miscomp++; $display("FAIL to_ready: got %b want 1", wb_ready); end
    tick();
    vec++; if (load_err !== 1'b0) begin miscomp++; $display("FAIL to_err_pulse: got %b want 0", load_err); end
  endtask

  task automatic test_reset_mid_load();
    drive(1'b1, 1'b1, 5'd11, 2'd1, 32'h0000_4000, 3'b010, 1'b0, 32'd0);
    tick();
    wb_valid = 1'b0;
    tick();
    rst             = 1'b1;
    mem_rdata_valid = 1'b1;
    mem_rdata       = 32'h7777_7777;
    tick();
    rst = 1'b0;
    vec++; if (rf_wr_en !== 1'b0 || rf_wr_addr !== 5'd0 || rf_wr_data !== 32'd0 || load_err !== 1'b0) begin
      miscomp++; $display("FAIL rml_outs: got en=%b addr=%0d data=%h err=%b want all 0", rf_wr_en, rf_wr_addr, rf_wr_data, load_err);
    end
    vec++; if (wb_ready !== 1'b1 || wb_busy !== 1'b0) begin
      miscomp++; $display("FAIL rml_state: got ready=%b busy=%b want 1 0", wb_ready, wb_busy);
    end
    tick();
    mem_rdata_valid = 1'b0;
    vec++; if (rf_wr_en !== 1'b0) begin miscomp++; $display("FAIL rml_no_write: got %b want 0", rf_wr_en); end
  endtask

  task automatic test_random();
    bit          m_pend;
    logic        m_rw;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    logic [1:0]  m_off;
    int          m_waited;
    int          thresh;
    logic        exp_en;
    logic        exp_err;
    logic        exp_ready;
    logic [4:0]  last_addr;
    logic [31:0] last_data;
    logic [31:0] val;
    rst = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 3'd0, 1'b0, 32'd0);
    tick();
    rst       = 1'b0;
    m_pend    = 1'b0;
    m_rw      = 1'b0;
    m_rd      = 5'd0;
    m_f3      = 3'd0;
    m_off     = 2'd0;
    m_waited  = 0;
    last_addr = 5'd0;
    last_data = 32'd0;
    for (int i = 0; i < 400; i++) begin
      case (i / 100)
        0:       thresh = 3;
        1:       thresh = 0;
        2:       thresh = 8;
        default: thresh = 1;
      endcase
      wb_valid        = 1'($urandom_range(0, 1));
      wb_reg_write    = ($urandom_range(0, 3) != 0);
      wb_rd           = 5'($urandom_range(0, 31));
      wb_result_src   = 2'($urandom_range(0, 3));
      wb_alu_result   = $urandom;
      wb_pc_plus4     = $urandom;
      wb_funct3       = 3'($urandom_range(0, 7));
      mem_rdata_valid = ($urandom_range(0, 9) < thresh);
      mem_rdata       = $urandom;
      exp_en    = 1'b0;
      exp_err   = 1'b0;
      exp_ready = !m_pend;
      val       = 32'd0;
      if (!m_pend) begin
        if (wb_valid) begin
          if (wb_result_src != 2'd1 || mem_rdata_valid) begin
            case (wb_result_src)
              2'd0:    val = wb_alu_result;
              2'd1:    val = ext_ref(wb_funct3, wb_alu_result[1:0], mem_rdata);
              2'd2:    val = wb_pc_plus4;
              default: val = 32'd0;
            endcase
            if (wb_reg_write && wb_rd != 5'd0) begin
              exp_en = 1'b1; last_addr = wb_rd; last_data = val;
            end
          end else begin
            m_pend = 1'b1; m_rw = wb_reg_write; m_rd = wb_rd;
            m_f3 = wb_funct3; m_off = wb_alu_result[1:0]; m_waited = 0;
          end
        end
      end else if (mem_rdata_valid) begin
        m_pend = 1'b0;
        val    = ext_ref(m_f3, m_off, mem_rdata);
        if (m_rw && m_rd != 5'd0) begin
          exp_en = 1'b1; last_addr = m_rd; last_data = val;
        end
      end else begin
        m_waited++;
        if (m_waited == LOAD_TIMEOUT) begin
          m_pend  = 1'b0;
          exp_err = 1'b1;
        end
      end
      vec++; if (wb_ready !== exp_ready || wb_busy !== !exp_ready) begin
        miscomp++; $display("FAIL rnd_handshake[%0d]: got ready=%b busy=%b want ready=%b", i, wb_ready, wb_busy, exp_ready);
      end
      tick();
      vec++; if (rf_wr_en !== exp_en || load_err !== exp_err) begin
        miscomp++; $display("FAIL rnd_strobe[%0d]: got en=%b err=%b want en=%b err=%b", i, rf_wr_en, load_err, exp_en, exp_err);
      end
      vec++; if (rf_wr_addr !== last_addr || rf_wr_data !== last_data) begin
        miscomp++; $display("FAIL rnd_port[%0d]: got %0d/%h want %0d/%h", i, rf_wr_addr, rf_wr_data, last_addr, last_data);
      end
    end
  endtask

  initial begin
    vec     = 0;
    miscomp = 0;
    rst     = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 3'd0, 1'b0, 32'd0);
    test_reset();
    test_alu();
    test_rd0();
    test_load_same_cycle();
    test_load_wait();
    test_timeout();
    test_reset_mid_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscomp);
    $finish;
  end

endmodule
